fifo_port_scheduler: RTL and testbench

- Controller that shares the single port of the 16-deep, 6-bit FIFO between NUM_PRODUCERS writers and one consumer.
- The FIFO port does either a write or a pop per clock, never both. This block picks the operation each cycle and drives the FIFO's write/pop/data/clear controls.
- It keeps a shadow occupancy count so the FIFO's full and empty are known without reading the FIFO back.
- It also sequences a post-reset clear and a software-requested flush.

---
 rtl/fifo_port_scheduler_if.sv | 29 ++
 rtl/fifo_port_scheduler.sv | 76 +++++++
 tb/tb_fifo_port_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fifo_port_scheduler_if.sv
// fifo_port_scheduler_if: producer/consumer handshake and FIFO control bundle for the port scheduler
interface fifo_port_scheduler_if #(
  parameter int NUM_PRODUCERS = 4,
  parameter int DATA_WIDTH    = 6,
  parameter int LEVEL_W       = 5
);
  logic [NUM_PRODUCERS-1:0]            prod_valid;
  logic [NUM_PRODUCERS*DATA_WIDTH-1:0] prod_data;
  logic [NUM_PRODUCERS-1:0]            prod_ready;
  logic                                pop_req;
  logic                                pop_ack;
  logic                                flush;
  logic                                fifo_write_en;
  logic                                fifo_pop;
  logic [DATA_WIDTH-1:0]               fifo_data;
  logic                                fifo_clear;
  logic [LEVEL_W-1:0]                  level;
  logic                                full;
  logic                                empty;
  logic                                busy;
  modport master (
    output prod_valid, prod_data, pop_req, flush,
    input  prod_ready, pop_ack, fifo_write_en, fifo_pop, fifo_data, fifo_clear, level, full, empty, busy
  );
  modport slave (
    input  prod_valid, prod_data, pop_req, flush,
    output prod_ready, pop_ack, fifo_write_en, fifo_pop, fifo_data, fifo_clear, level, full, empty, busy
  );
endinterface

// File: rtl/fifo_port_scheduler.sv
// fifo_port_scheduler: arbitrates one write-or-pop per cycle on a shared FIFO port with shadow occupancy, init clear and flush
module fifo_port_scheduler #(
  parameter int NUM_PRODUCERS = 4,
  parameter int DATA_WIDTH    = 6,
  parameter int DEPTH         = 16,
  parameter int LEVEL_W       = 5
) (
  input logic                clk,
  input logic                reset,
  fifo_port_scheduler_if.slave bus
);
  localparam int PW = NUM_PRODUCERS > 1 ? $clog2(NUM_PRODUCERS) : 1;
  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic OP_POP   = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  logic [1:0]         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d, lvl;
  logic               last_op_q, last_op_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d, win;
  logic [PW:0]        idx;
  logic               in_run, in_flush, is_full, is_empty, w_ok, p_ok, do_w, do_p, do_f;
  // Scan downward so the lowest offset from rr_ptr is the one left standing
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NUM_PRODUCERS-1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
      idx = idx >= (PW+1)'(NUM_PRODUCERS) ? idx - (PW+1)'(NUM_PRODUCERS) : idx;
      if (bus.prod_valid[idx[PW-1:0]]) win = idx[PW-1:0];
    end
  end
  // Reset masks the registered level so outputs show the cleared view immediately
  always_comb begin
    lvl       = reset ? '0 : level_q;
    is_full   = lvl == LEVEL_W'(DEPTH);
    is_empty  = lvl == '0;
    in_run    = !reset && state_q == ST_RUN;
    in_flush  = !reset && state_q == ST_FLUSH;
    w_ok      = in_run && |bus.prod_valid && !is_full;
    p_ok      = in_run && bus.pop_req && !is_empty;
    do_w      = w_ok && (!p_ok || last_op_q == OP_POP);
    do_p      = p_ok && (!w_ok || last_op_q == OP_WRITE);
    do_f      = in_flush && !is_empty;
    level_d   = do_w ? lvl + 1'b1 : (do_p || do_f) ? lvl - 1'b1 : lvl;
    last_op_d = do_w ? OP_WRITE : do_p ? OP_POP : last_op_q;
    rr_ptr_d  = !do_w ? rr_ptr_q : win == PW'(NUM_PRODUCERS-1) ? '0 : win + 1'b1;
    state_d   = state_q == ST_INIT ? ST_RUN :
                state_q == ST_RUN  ? ((bus.flush && level_d != '0) ? ST_FLUSH : ST_RUN) :
                (level_d == '0 ? ST_RUN : ST_FLUSH);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      level_q   <= '0;
      last_op_q <= OP_POP;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      last_op_q <= last_op_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end
  assign bus.prod_ready    = do_w ? NUM_PRODUCERS'(1) << win : '0;
  assign bus.pop_ack       = do_p;
  assign bus.fifo_write_en = do_w;
  assign bus.fifo_pop      = do_p || do_f;
  assign bus.fifo_data     = do_w ? bus.prod_data[int'(win)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.fifo_clear    = reset || state_q == ST_INIT;
  assign bus.level         = lvl;
  assign bus.full          = is_full;
  assign bus.empty         = is_empty;
  assign bus.busy          = reset || state_q != ST_RUN;
endmodule

// File: tb/tb_fifo_port_scheduler.sv
// tb_fifo_port_scheduler: directed plus random stimulus against a queue-based model of the shared FIFO port
module tb_fifo_port_scheduler;
  localparam int N = 4;
  localparam int DW = 6;
  localparam int DEPTH = 16;
  localparam int LW = 5;
  localparam int M_INIT = 0;
  localparam int M_RUN = 1;
  localparam int M_FLUSH = 2;
  logic clk = 1'b0;
  logic reset;
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] q[$];
  int mode = M_INIT;
  bit last_w = 1'b0;
  int rr = 0;
  fifo_port_scheduler_if #(.NUM_PRODUCERS(N), .DATA_WIDTH(DW), .LEVEL_W(LW)) bus();
  fifo_port_scheduler #(.NUM_PRODUCERS(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LEVEL_W(LW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit rst, input logic [N-1:0] v, input logic [N*DW-1:0] d, input bit pr, input bit fl);
    int win;
    bit cw, cp, wr, pp, fp;
    logic [DW-1:0] wd;
    @(negedge clk);
    reset = rst;
    bus.prod_valid = v;
    bus.prod_data = d;
    bus.pop_req = pr;
    bus.flush = fl;
    #1;
    win = 0;
    wr = 0;
    pp = 0;
    wd = '0;
    cw = (v != 0) && q.size() < DEPTH;
    cp = pr && q.size() > 0;
    if (!rst && mode == M_RUN) begin
      wr = cw && (!cp || !last_w);
      pp = cp && (!cw || last_w);
    end
    if (wr) begin
      for (int k = 0; k < N; k++) begin
        if (v[(rr + k) % N]) begin
          win = (rr + k) % N;
          break;
        end
      end
      wd = d[win*DW +: DW];
    end
    fp = !rst && mode == M_FLUSH && q.size() > 0;
    check("prod_ready", bus.prod_ready, wr ? (32'd1 << win) : 32'd0);
    check("pop_ack", bus.pop_ack, pp);
    check("fifo_write_en", bus.fifo_write_en, wr);
    check("fifo_pop", bus.fifo_pop, pp || fp);
    check("fifo_data", bus.fifo_data, wd);
    check("fifo_clear", bus.fifo_clear, rst || mode == M_INIT);
    check("level", bus.level, rst ? 0 : q.size());
    check("full", bus.full, !rst && q.size() == DEPTH);
    check("empty", bus.empty, rst || q.size() == 0);
    check("busy", bus.busy, rst || mode != M_RUN);
    @(posedge clk);
    if (rst) begin
      q.delete();
      mode = M_INIT;
      last_w = 0;
      rr = 0;
    end else if (mode == M_INIT) begin
      mode = M_RUN;
    end else if (mode == M_RUN) begin
      if (wr) begin
        q.push_back(wd);
        rr = (win + 1) % N;
        last_w = 1;
      end
      if (pp) begin
        void'(q.pop_front());
        last_w = 0;
      end
      if (fl && q.size() > 0) mode = M_FLUSH;
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (q.size() == 0) mode = M_RUN;
    end
  endtask
  function automatic logic [N*DW-1:0] rnd_data();
    return (N*DW)'($urandom());
  endfunction
  initial begin
    int ph;
    logic [N-1:0] v;
    reset = 1'b1;
    bus.prod_valid = '0;
    bus.prod_data = '0;
    bus.pop_req = 1'b0;
    bus.flush = 1'b0;
    repeat (3) step(1, '0, '0, 0, 0);
    step(0, '0, '0, 0, 0);
    repeat (20) step(0, 4'b0101, rnd_data(), 0, 0);
    #1;
    check("fill_full", bus.full, 1'b1);
    check("fill_level", bus.level, 16);
    repeat (12) step(0, '0, '0, 1, 0);
    step(0, 4'b0001, rnd_data(), 0, 0);
    repeat (8) step(0, 4'b1111, rnd_data(), 1, 0);
    #1;
    check("osc_level", bus.level, 5);
    repeat (7) step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);
    step(0, 4'b1000, (N*DW)'(6'h2A) << (3*DW), 1, 0);
    step(0, '0, '0, 1, 0);
    repeat (7) step(0, 4'b0100, rnd_data(), 0, 0);
    step(0, 4'b0010, rnd_data(), 0, 1);
    repeat (9) step(0, 4'b0010, rnd_data(), 0, 0);
    #1;
    check("flush_empty", bus.empty, 1'b0);
    repeat (9) step(0, '0, '0, 1, 0);
    repeat (6) step(0, 4'b1111, rnd_data(), 0, 0);
    step(0, '0, '0, 0, 1);
    repeat (2) step(0, '0, '0, 0, 0);
    step(1, '0, '0, 0, 0);
    repeat (4) step(0, '0, '0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      ph = (i / 150) % 3;
      v = N'($urandom());
      if (ph == 1 && $urandom_range(0, 3) != 0) v = '0;
      step($urandom_range(0, 299) == 0, v, rnd_data(),
           ph == 0 ? $urandom_range(0, 3) == 0 : ph == 1 ? 1'b1 : 1'($urandom()),
           $urandom_range(0, 39) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
